uart_rx_fifo: RTL and testbench

- Receive-side buffer directly downstream of the UART receiver.
- Captures each received frame (P_DATA qualified by data_valid) into a circular FIFO and presents it to the consumer over a valid/ready interface.
- Reports fill level, almost-full and a sticky overrun flag, so no frame is silently lost when the consumer stalls.

---
 rtl/uart_rx_fifo.sv | 60 ++++++
 tb/tb_uart_rx_fifo.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: buffers UART receiver frames in a circular FIFO with valid/ready read side,
// fill level, almost-full and a sticky overrun flag.
module uart_rx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int AF_LEVEL   = 6
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     data_valid,
    input  logic [DATA_WIDTH-1:0]    P_DATA,
    input  logic                     RD_READY,
    input  logic                     CLR_OVR,
    output logic [DATA_WIDTH-1:0]    RD_DATA,
    output logic                     RD_VALID,
    output logic [$clog2(DEPTH):0]   FIFO_LEVEL,
    output logic                     FULL,
    output logic                     ALMOST_FULL,
    output logic                     OVERRUN
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr, r_rd_ptr;
    logic [LW-1:0]         r_level;
    logic                  r_dv_q, r_ovr;
    logic                  w_push_req, w_pop, w_push, w_drop;

    assign w_push_req = data_valid & ~r_dv_q;
    assign w_pop      = RD_VALID & RD_READY;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign w_push     = w_push_req & (~FULL | w_pop);
    assign w_drop     = w_push_req & FULL & ~w_pop;

    assign RD_DATA     = r_mem[r_rd_ptr];
    assign RD_VALID    = r_level != '0;
    assign FIFO_LEVEL  = r_level;
    assign FULL        = r_level == LW'(DEPTH);
    assign ALMOST_FULL = r_level >= LW'(AF_LEVEL);
    assign OVERRUN     = r_ovr;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_dv_q   <= 1'b0;
            r_ovr    <= 1'b0;
        end else begin
            if (w_push) r_mem[r_wr_ptr] <= P_DATA;
            r_wr_ptr <= r_wr_ptr + AW'(w_push);
            r_rd_ptr <= r_rd_ptr + AW'(w_pop);
            r_level  <= r_level + LW'(w_push) - LW'(w_pop);
            r_dv_q   <= data_valid;
            r_ovr    <= w_drop | (r_ovr & ~CLR_OVR);
        end
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed self-checking bench for uart_rx_fifo (DEPTH 8, AF_LEVEL 6).
module tb_uart_rx_fifo;
    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       data_valid = 1'b0;
    logic [7:0] P_DATA = '0;
    logic       RD_READY = 1'b0;
    logic       CLR_OVR = 1'b0;
    logic [7:0] RD_DATA;
    logic       RD_VALID;
    logic [3:0] FIFO_LEVEL;
    logic       FULL, ALMOST_FULL, OVERRUN;
    int         checks = 0;
    int         failures = 0;

    uart_rx_fifo #(.DATA_WIDTH(8), .DEPTH(8), .AF_LEVEL(6)) dut (
        .CLK(CLK), .RST(RST), .data_valid(data_valid), .P_DATA(P_DATA),
        .RD_READY(RD_READY), .CLR_OVR(CLR_OVR), .RD_DATA(RD_DATA),
        .RD_VALID(RD_VALID), .FIFO_LEVEL(FIFO_LEVEL), .FULL(FULL),
        .ALMOST_FULL(ALMOST_FULL), .OVERRUN(OVERRUN)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        data_valid = 1'b1;
        P_DATA = b;
        tick();
        data_valid = 1'b0;
        tick();
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, 32'(RD_VALID), 0);
        chk({tag, "_data"}, 32'(RD_DATA), 0);
        chk({tag, "_level"}, 32'(FIFO_LEVEL), 0);
        chk({tag, "_full"}, 32'(FULL), 0);
        chk({tag, "_af"}, 32'(ALMOST_FULL), 0);
        chk({tag, "_ovr"}, 32'(OVERRUN), 0);
    endtask

    initial begin
        repeat (3) tick();
        chk_idle("reset");
        RST = 1'b1;
        tick();

        // single push and pop
        data_valid = 1'b1; P_DATA = 8'hA5;
        tick();
        data_valid = 1'b0;
        chk("push1_valid", 32'(RD_VALID), 1);
        chk("push1_data", 32'(RD_DATA), 32'hA5);
        chk("push1_level", 32'(FIFO_LEVEL), 1);
        RD_READY = 1'b1;
        tick();
        RD_READY = 1'b0;
        chk("pop1_valid", 32'(RD_VALID), 0);
        chk("pop1_level", 32'(FIFO_LEVEL), 0);

        // held data_valid yields one push
        data_valid = 1'b1; P_DATA = 8'h3C;
        repeat (5) tick();
        data_valid = 1'b0;
        tick();
        chk("hold_level", 32'(FIFO_LEVEL), 1);
        chk("hold_data", 32'(RD_DATA), 32'h3C);
        RD_READY = 1'b1;
        tick();
        RD_READY = 1'b0;
        chk("hold_drain", 32'(FIFO_LEVEL), 0);

        // fill to full, then overflow
        for (int i = 1; i <= 8; i++) begin
            push(8'(i));
            chk($sformatf("fill_level%0d", i), 32'(FIFO_LEVEL), 32'(i));
            chk($sformatf("fill_af%0d", i), 32'(ALMOST_FULL), 32'(i >= 6));
            chk($sformatf("fill_full%0d", i), 32'(FULL), 32'(i == 8));
        end
        chk("pre_ovr", 32'(OVERRUN), 0);
        push(8'h09);
        chk("ovr_set", 32'(OVERRUN), 1);
        chk("ovr_level", 32'(FIFO_LEVEL), 8);
        RD_READY = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("drain1_%0d", i), 32'(RD_DATA), 32'(i));
            tick();
        end
        RD_READY = 1'b0;
        chk("drain1_valid", 32'(RD_VALID), 0);
        chk("drain1_level", 32'(FIFO_LEVEL), 0);
        chk("ovr_sticky", 32'(OVERRUN), 1);

        CLR_OVR = 1'b1;
        tick();
        CLR_OVR = 1'b0;
        chk("ovr_clr", 32'(OVERRUN), 0);
        chk("ovr_clr_level", 32'(FIFO_LEVEL), 0);

        // second fill exercises pointer wrap
        for (int i = 1; i <= 8; i++) push(8'(8'h10 + i));
        chk("fill2_full", 32'(FULL), 1);
        chk("fill2_head", 32'(RD_DATA), 32'h11);

        // push while full with concurrent pop
        data_valid = 1'b1; P_DATA = 8'h55; RD_READY = 1'b1;
        tick();
        data_valid = 1'b0; RD_READY = 1'b0;
        chk("pp_level", 32'(FIFO_LEVEL), 8);
        chk("pp_ovr", 32'(OVERRUN), 0);
        chk("pp_head", 32'(RD_DATA), 32'h12);
        tick();

        // clear coinciding with a drop: set wins
        data_valid = 1'b1; P_DATA = 8'h66; CLR_OVR = 1'b1;
        tick();
        data_valid = 1'b0; CLR_OVR = 1'b0;
        chk("clr_drop_ovr", 32'(OVERRUN), 1);
        chk("clr_drop_level", 32'(FIFO_LEVEL), 8);
        RD_READY = 1'b1;
        for (int i = 2; i <= 8; i++) begin
            chk($sformatf("drain2_%0d", i), 32'(RD_DATA), 32'(8'h10 + i));
            tick();
        end
        chk("drain2_last", 32'(RD_DATA), 32'h55);
        tick();
        RD_READY = 1'b0;
        chk("drain2_valid", 32'(RD_VALID), 0);

        // asynchronous reset mid-operation
        CLR_OVR = 1'b1;
        tick();
        CLR_OVR = 1'b0;
        push(8'h71); push(8'h72); push(8'h73);
        chk("pre_rst_level", 32'(FIFO_LEVEL), 3);
        #2 RST = 1'b0;
        #1;
        chk_idle("async_rst");
        tick();
        RST = 1'b1;
        repeat (3) tick();
        chk("post_rst_valid", 32'(RD_VALID), 0);
        push(8'h99);
        chk("post_rst_push_valid", 32'(RD_VALID), 1);
        chk("post_rst_push_data", 32'(RD_DATA), 32'h99);
        chk("post_rst_push_level", 32'(FIFO_LEVEL), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
